// File: rtl/frame_tick_pkg.sv
// rtl/frame_tick_pkg.sv - shared constants and types for the frame tick generator
package frame_tick_pkg;

  // Reload values for 60 Hz and 30 Hz frames from a 50 MHz clock
  localparam int RATE_60HZ_50MHZ = 833332;
  localparam int RATE_30HZ_50MHZ = 1666666;

  typedef enum logic [1:0] {
    CH_HOLD,
    CH_COUNT,
    CH_TICK
  } ch_action_e;

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/frame_tick_channel.sv
// rtl/frame_tick_channel.sv - one tick channel: rate, down-counter, frame index, pending, overrun
// Optional overrun tracking is built when FRAME_TICK_OVERRUN_EN is defined.
module frame_tick_channel
  import frame_tick_pkg::*;
#(
  parameter int CNT_W        = 23,
  parameter int IDX_W        = 8,
  parameter int DEFAULT_RATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             ack,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_rate,
  output logic             tick,
  output logic             pending,
  output logic             overrun,
  output logic [IDX_W-1:0] frame_idx
);

  logic [CNT_W-1:0] rate_q, rate_d, cnt_q, cnt_d, rate_eff;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick_q, tick_d, pending_q, pending_d;
  ch_action_e       action;

  always_comb begin
    rate_eff = wr_en ? wr_rate : rate_q;
    rate_d   = rate_eff;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    if (!run)                action = CH_HOLD;
    else if (cnt_q == '0)    action = CH_TICK;
    else                     action = CH_COUNT;
    case (action)
      CH_HOLD:  cnt_d = rate_eff;
      CH_COUNT: cnt_d = cnt_q - CNT_W'(1);
      CH_TICK: begin
        tick_d = 1'b1;
        cnt_d  = rate_eff;
        idx_d  = idx_q + IDX_W'(1);
      end
      default:  cnt_d = rate_eff;
    endcase
    // A new tick outranks a simultaneous ack
    pending_d = tick_d | (pending_q & ~ack);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rate_q    <= CNT_W'(DEFAULT_RATE);
      cnt_q     <= CNT_W'(DEFAULT_RATE);
      idx_q     <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

`ifdef FRAME_TICK_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = (tick_d & pending_q & ~ack) | (overrun_q & ~wr_en);
  end

  always_ff @(posedge clock) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign tick      = tick_q;
  assign pending   = pending_q;
  assign frame_idx = idx_q;

endmodule

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - multi-channel programmable frame tick generator
// Overrun flags are built only when FRAME_TICK_OVERRUN_EN is defined.
module frame_tick_gen
  import frame_tick_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 23,
  parameter int IDX_W        = 8,
  parameter int DEFAULT_RATE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [ch_w(CHANNELS)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_rate,
  input  logic [CHANNELS-1:0]       run,
  input  logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS*IDX_W-1:0] frame_idx,
  output logic [CHANNELS-1:0]       overrun
);

  logic [CHANNELS-1:0] wr_en;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Channel numbers at or above CHANNELS never match, so such writes are dropped
    assign wr_en[i] = cfg_we && (int'(cfg_ch) == i);

    frame_tick_channel #(
      .CNT_W       (CNT_W),
      .IDX_W       (IDX_W),
      .DEFAULT_RATE(DEFAULT_RATE)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .run      (run[i]),
      .ack      (ack[i]),
      .wr_en    (wr_en[i]),
      .wr_rate  (cfg_rate),
      .tick     (tick[i]),
      .pending  (pending[i]),
      .overrun  (overrun[i]),
      .frame_idx(frame_idx[i*IDX_W +: IDX_W])
    );
  end

endmodule

// File: tb/tb_frame_tick_gen.sv
// tb/tb_frame_tick_gen.sv - self-checking bench for frame_tick_gen (vectors, corner sequences, random vs model)
module tb_frame_tick_gen;
  localparam int CH = 5;
  localparam int CW = 23;
  localparam int IW = 8;
`ifdef FRAME_TICK_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset, cfg_we;
  logic [2:0]     cfg_ch;
  logic [CW-1:0]  cfg_rate;
  logic [CH-1:0]  run, ack, tick, pending, overrun;
  logic [CH*IW-1:0] frame_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  frame_tick_gen #(.CHANNELS(CH), .CNT_W(CW), .IDX_W(IW), .DEFAULT_RATE(0)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_rate(cfg_rate),
    .run(run), .ack(ack), .tick(tick), .pending(pending), .frame_idx(frame_idx),
    .overrun(overrun)
  );

  typedef struct {
    logic          rst, we;
    logic [2:0]    ch;
    logic [CW-1:0] rate;
    logic [CH-1:0] run, ack, e_tick, e_pend;
    logic [IW-1:0] e_idx0;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic rst, we, input int ch, rate,
                              input logic [CH-1:0] rn, ak, et, ep, input int ei);
    vec_t v;
    v.rst = rst; v.we = we; v.ch = 3'(ch); v.rate = CW'(rate);
    v.run = rn; v.ack = ak; v.e_tick = et; v.e_pend = ep; v.e_idx0 = IW'(ei);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_rate = '0; run = '0; ack = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input int ch, input int r);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_rate = CW'(r);
    step();
    cfg_we = 1'b0;
  endtask

  function automatic logic [IW-1:0] idx(input int ch);
    return frame_idx[ch*IW +: IW];
  endfunction

  // Reference model: each period length is fixed when the period begins
  int m_rate[CH], m_len[CH], m_el[CH], m_ticks[CH];
  bit m_tick[CH], m_pend[CH], m_ovr[CH];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_rate[i] = 0; m_len[i] = 1; m_el[i] = 0; m_ticks[i] = 0;
      m_tick[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      bit wr_i, nt;
      int eff;
      wr_i = cfg_we && (int'(cfg_ch) == i);
      eff  = wr_i ? int'(cfg_rate) : m_rate[i];
      nt   = 0;
      if (!run[i]) begin
        m_el[i] = 0; m_len[i] = eff + 1;
      end else begin
        m_el[i]++;
        if (m_el[i] == m_len[i]) begin
          nt = 1; m_el[i] = 0; m_len[i] = eff + 1; m_ticks[i]++;
        end
      end
      if (OVR_EN) m_ovr[i] = (nt && m_pend[i] && !ack[i]) || (m_ovr[i] && !wr_i);
      m_pend[i] = nt || (m_pend[i] && !ack[i]);
      m_tick[i] = nt;
      m_rate[i] = eff;
    end
  endtask

  initial begin
    logic [CH-1:0] et, ep, eo;
    logic [CH*IW-1:0] ei;
    idle();

    // Rate 3 on ch0: ticks after run edges 4, 8, 12; ack and out-of-range write mixed in
    tbl[0]  = mk(1, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0);
    tbl[1]  = mk(0, 1, 0, 3, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0);
    tbl[2]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0);
    tbl[3]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0);
    tbl[4]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0);
    tbl[5]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 1);
    tbl[6]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1);
    tbl[7]  = mk(0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1);
    tbl[8]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1);
    tbl[9]  = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 2);
    tbl[10] = mk(0, 1, 5, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2);
    tbl[11] = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2);
    tbl[12] = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2);
    tbl[13] = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 3);
    tbl[14] = mk(0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 3);
    tbl[15] = mk(0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 3);

    for (int r = 0; r < 16; r++) begin
      reset = tbl[r].rst; cfg_we = tbl[r].we; cfg_ch = tbl[r].ch; cfg_rate = tbl[r].rate;
      run = tbl[r].run; ack = tbl[r].ack;
      step();
      chk($sformatf("tbl%0d_tick", r), 64'(tick), 64'(tbl[r].e_tick));
      chk($sformatf("tbl%0d_pending", r), 64'(pending), 64'(tbl[r].e_pend));
      chk($sformatf("tbl%0d_idx", r), 64'(frame_idx), 64'(tbl[r].e_idx0));
    end

    // Rate 0: tick every cycle, index wraps 255 -> 0 on the 256th tick
    do_reset();
    wr(1, 0);
    run = 5'b00010;
    for (int n = 1; n <= 257; n++) begin
      step();
      chk("r0_tick_every_cycle", 64'(tick[1]), 64'd1);
      if (n >= 255) chk($sformatf("r0_idx_after_%0d", n), 64'(idx(1)), 64'(n % 256));
    end
    chk("r0_other_silent", 64'({tick[4:2], tick[0]}), 64'd0);

    // Rate change mid-period takes effect only at the next reload
    do_reset();
    wr(2, 9);
    run = 5'b00100;
    for (int e = 1; e <= 16; e++) begin
      if (e == 5) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_rate = CW'(2); end
      step();
      cfg_we = 1'b0;
      chk($sformatf("midwr_tick_e%0d", e), 64'(tick[2]), 64'(e == 10 || e == 13 || e == 16));
    end

    // Pending stickiness, ack colliding with tick, overrun
    do_reset();
    wr(3, 1);
    run = 5'b01000;
    step(); step();
    chk("pend_first_tick", 64'({tick[3], pending[3]}), 64'b11);
    step(); step();
    chk("pend_unacked", 64'(pending[3]), 64'd1);
    chk("ovr_second_unacked", 64'(overrun[3]), 64'(OVR_EN));
    step();
    ack = 5'b01000;
    step();
    ack = '0;
    chk("ack_vs_tick", 64'({tick[3], pending[3]}), 64'b11);
    chk("ovr_sticky", 64'(overrun[3]), 64'(OVR_EN));
    run = '0;
    wr(3, 5);
    chk("ovr_cleared_by_cfg", 64'(overrun[3]), 64'd0);

    // Reset mid-period with pending set
    do_reset();
    wr(0, 4);
    run = 5'b00001;
    for (int e = 0; e < 5; e++) step();
    chk("pre_reset_tick", 64'({tick[0], pending[0]}), 64'b11);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_outputs", 64'({tick, pending, overrun}), 64'd0);
    chk("rst_idx", 64'(frame_idx), 64'd0);
    step();
    chk("rst_default_rate_t1", 64'(tick[0]), 64'd1);
    step();
    chk("rst_default_rate_t2", 64'(tick[0]), 64'd1);

    // Pause mid-period; out-of-range write during the pause
    do_reset();
    wr(0, 3);
    run = 5'b00001;
    for (int e = 0; e < 6; e++) step();
    chk("pause_idx_before", 64'(idx(0)), 64'd1);
    run = '0;
    for (int e = 0; e < 5; e++) begin
      if (e == 2) begin cfg_we = 1'b1; cfg_ch = 3'd5; cfg_rate = CW'(7); end
      step();
      cfg_we = 1'b0;
      chk("pause_no_tick", 64'(tick[0]), 64'd0);
      chk("pause_idx_hold", 64'(idx(0)), 64'd1);
    end
    run = 5'b00001;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("resume_tick_e%0d", e), 64'(tick[0]), 64'(e == 4));
    end
    chk("resume_idx", 64'(idx(0)), 64'd2);

    // Randomized traffic against the reference model
    idle();
    reset = 1'b1;
    model_step();
    step();
    for (int c = 0; c < 2000; c++) begin
      reset    = ($urandom_range(199, 0) == 0);
      cfg_we   = ($urandom_range(9, 0) == 0);
      cfg_ch   = 3'($urandom_range(7, 0));
      cfg_rate = CW'($urandom_range(6, 0));
      for (int i = 0; i < CH; i++) begin
        run[i] = ($urandom_range(9, 0) != 0);
        ack[i] = ($urandom_range(4, 0) == 0);
      end
      model_step();
      step();
      for (int i = 0; i < CH; i++) begin
        et[i] = m_tick[i]; ep[i] = m_pend[i]; eo[i] = m_ovr[i];
        ei[i*IW +: IW] = IW'(m_ticks[i] % 256);
      end
      chk($sformatf("rand_tick_c%0d", c), 64'(tick), 64'(et));
      chk($sformatf("rand_pending_c%0d", c), 64'(pending), 64'(ep));
      chk($sformatf("rand_overrun_c%0d", c), 64'(overrun), 64'(eo));
      chk($sformatf("rand_idx_c%0d", c), 64'(frame_idx), 64'(ei));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
